// File: rtl/grid_ram_mp_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// grid_ram_mp_if : write / multi-read / row-clear bus of the grid RAM
// Revision 1.0
// ---------------------------------------------------------------------------
interface grid_ram_mp_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 32,
  parameter int NUM_RD     = 2
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                         we;
  logic [RW-1:0]                w_row;
  logic [CW-1:0]                w_col;
  logic [DATA_WIDTH-1:0]        din;
  logic                         w_ready;
  logic [NUM_RD-1:0]            rd_en;
  logic [NUM_RD*RW-1:0]         r_row;
  logic [NUM_RD*CW-1:0]         r_col;
  logic [NUM_RD*DATA_WIDTH-1:0] dout;
  logic [NUM_RD-1:0]            dout_valid;
  logic                         clr_req;
  logic [RW-1:0]                clr_row;
  logic                         clr_busy;
  logic                         clr_done;

  modport master (
    output we, w_row, w_col, din, rd_en, r_row, r_col, clr_req, clr_row,
    input  w_ready, dout, dout_valid, clr_busy, clr_done
  );

  modport slave (
    input  we, w_row, w_col, din, rd_en, r_row, r_col, clr_req, clr_row,
    output w_ready, dout, dout_valid, clr_busy, clr_done
  );
endinterface
`default_nettype wire

// File: rtl/grid_ram_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// grid_ram_mp : 2D RAM, one write port, NUM_RD sync read ports, row clear
// Revision 1.0
// ---------------------------------------------------------------------------
module grid_ram_mp #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 32,
  parameter int NUM_RD     = 2,
  parameter int RD_BYPASS  = 1,
  parameter int CLR_VALUE  = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  grid_ram_mp_if.slave   bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW:0]           ROWS_L   = (RW+1)'(ROWS);
  localparam logic [CW:0]           COLS_L   = (CW+1)'(COLS);
  localparam logic [CW-1:0]         COL_LAST = CW'(COLS - 1);
  localparam logic [DATA_WIDTH-1:0] CLR_V    = DATA_WIDTH'(CLR_VALUE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [RW-1:0]                clr_row_q, clr_row_d;
  logic [CW-1:0]                col_q, col_d;
  logic [NUM_RD*DATA_WIDTH-1:0] dout_q, dout_d, rd_data;
  logic [NUM_RD-1:0]            valid_q, valid_d;
  logic [DATA_WIDTH-1:0]        mem [ROWS][COLS];

  logic w_in_rng, clr_in_rng, wr_acc, clr_wr;

  assign w_in_rng   = ({1'b0, bus.w_row} < ROWS_L) && ({1'b0, bus.w_col} < COLS_L);
  assign clr_in_rng = ({1'b0, bus.clr_row} < ROWS_L);
  assign clr_wr     = rst_n && (state_q == S_CLEAR);
  assign wr_acc     = rst_n && bus.we && bus.w_ready && w_in_rng;

  assign bus.w_ready    = (state_q != S_CLEAR);
  assign bus.clr_busy   = (state_q == S_CLEAR);
  assign bus.clr_done   = (state_q == S_DONE);
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;

  // User writes and clear writes never coincide: w_ready is low during CLEAR.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[bus.w_row][bus.w_col] <= bus.din;
    end else if (clr_wr) begin
      mem[clr_row_q][col_q] <= CLR_V;
    end
  end

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [RW-1:0] row, row_idx;
      logic [CW-1:0] col, col_idx;
      logic          in_rng, hit_wr, hit_clr;

      assign row     = bus.r_row[k*RW +: RW];
      assign col     = bus.r_col[k*CW +: CW];
      assign in_rng  = ({1'b0, row} < ROWS_L) && ({1'b0, col} < COLS_L);
      // Clamp so the array is never indexed past its end.
      assign row_idx = in_rng ? row : '0;
      assign col_idx = in_rng ? col : '0;
      assign hit_wr  = wr_acc && (row == bus.w_row) && (col == bus.w_col);
      assign hit_clr = clr_wr && (row == clr_row_q) && (col == col_q);

      assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] =
          !in_rng                         ? '0      :
          ((RD_BYPASS != 0) && hit_wr)    ? bus.din :
          ((RD_BYPASS != 0) && hit_clr)   ? CLR_V   :
                                            mem[row_idx][col_idx];
    end
  endgenerate

  always_comb begin
    dout_d  = dout_q;
    valid_d = bus.rd_en;
    for (int k = 0; k < NUM_RD; k++) begin
      if (bus.rd_en[k]) begin
        dout_d[k*DATA_WIDTH +: DATA_WIDTH] = rd_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_row_d = clr_row_q;
    col_d     = col_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.clr_req && clr_in_rng) begin
          state_d   = S_CLEAR;
          clr_row_d = bus.clr_row;
          col_d     = '0;
        end
      end
      S_CLEAR: begin
        col_d = col_q + 1'b1;
        if (col_q == COL_LAST) begin
          state_d = S_DONE;
          col_d   = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      clr_row_q <= '0;
      col_q     <= '0;
      dout_q    <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_row_q <= clr_row_d;
      col_q     <= col_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
    end
  end
endmodule
`default_nettype wire
